// File: rtl/sys_ctrl_rsp.sv
// sys_ctrl_rsp: decodes host command frames into RF/ALU operations and pushes response bytes to the TX FIFO
module sys_ctrl_rsp #(
  parameter int DATA_WIDTH = 8,
  parameter int RF_ADDR    = 4,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [RF_ADDR-1:0]      RF_ADDR_O,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RF,
    OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;
  state_t                  state_q, state_d;
  logic [RF_ADDR-1:0]      rf_addr_q, rf_addr_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    clk_gate_en_q, clk_gate_en_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_q, tx_p_data_d;
  logic                    tx_d_vld_q, tx_d_vld_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  always_comb begin
    state_d       = state_q;
    rf_addr_d     = rf_addr_q;
    rf_wr_data_d  = rf_wr_data_q;
    alu_fun_d     = alu_fun_q;
    tx_p_data_d   = tx_p_data_q;
    data_d        = data_q;
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    clk_gate_en_d = 1'b0;
    tx_d_vld_d    = 1'b0;
    case (state_q)
      IDLE:
        if (RX_D_VLD)
          state_d = RX_P_DATA == DATA_WIDTH'(8'hAA) ? WR_ADDR :
                    RX_P_DATA == DATA_WIDTH'(8'hBB) ? RD_ADDR :
                    RX_P_DATA == DATA_WIDTH'(8'hCC) ? OPA :
                    RX_P_DATA == DATA_WIDTH'(8'hDD) ? FUN : IDLE;
      WR_ADDR:
        if (RX_D_VLD) begin
          rf_addr_d = RX_P_DATA[RF_ADDR-1:0];
          state_d   = WR_DATA;
        end
      WR_DATA:
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_wr_data_d = RX_P_DATA;
          state_d      = IDLE;
        end
      RD_ADDR:
        if (RX_D_VLD) begin
          rf_rd_en_d = 1'b1;
          rf_addr_d  = RX_P_DATA[RF_ADDR-1:0];
          state_d    = RD_WAIT;
        end
      RD_WAIT:
        if (RF_RD_DATA_VLD) begin
          data_d  = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
          state_d = TX_RF;
        end
      TX_RF:
        if (!FIFO_FULL) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = data_q[DATA_WIDTH-1:0];
          state_d     = IDLE;
        end
      OPA:
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = RF_ADDR'(OPA_ADDR);
          rf_wr_data_d = RX_P_DATA;
          state_d      = OPB;
        end
      OPB:
        if (RX_D_VLD) begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = RF_ADDR'(OPB_ADDR);
          rf_wr_data_d = RX_P_DATA;
          state_d      = FUN;
        end
      FUN:
        if (RX_D_VLD) begin
          alu_fun_d     = RX_P_DATA[3:0];
          alu_en_d      = 1'b1;
          clk_gate_en_d = 1'b1;
          state_d       = ALU_WAIT;
        end
      ALU_WAIT:
        if (ALU_OUT_VLD) begin
          data_d  = ALU_OUT;
          state_d = TX_LO;
        end else begin
          alu_en_d      = 1'b1;
          clk_gate_en_d = 1'b1;
        end
      TX_LO:
        if (!FIFO_FULL) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = data_q[DATA_WIDTH-1:0];
          state_d     = TX_HI;
        end
      TX_HI:
        if (!FIFO_FULL) begin
          tx_d_vld_d  = 1'b1;
          tx_p_data_d = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
          state_d     = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      rf_addr_q     <= '0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      tx_p_data_q   <= tx_p_data_d;
      tx_d_vld_q    <= tx_d_vld_d;
      data_q        <= data_d;
    end
  end
  assign RF_ADDR_O   = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_d_vld_q;
endmodule

// File: tb/tb_sys_ctrl_rsp.sv
// tb_sys_ctrl_rsp: scoreboard bench with RF and ALU response models
module tb_sys_ctrl_rsp;
  logic        CLK = 1'b0, RST_N = 1'b0, RX_D_VLD = 1'b0;
  logic        RF_RD_DATA_VLD = 1'b0, ALU_OUT_VLD = 1'b0, FIFO_FULL = 1'b0;
  logic [7:0]  RX_P_DATA = '0, RF_RD_DATA = '0;
  logic [15:0] ALU_OUT = '0;
  logic [3:0]  RF_ADDR_O, ALU_FUN;
  logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [7:0]  RF_WR_DATA, TX_P_DATA;
  int          checks = 0, errors = 0, alu_cnt = 0;
  logic [31:0] exp_wr[$], exp_rd[$], exp_tx[$];
  logic [31:0] e;
  logic [7:0]  mem [16];
  logic [15:0] alu_res = '0;
  logic [3:0]  exp_fun = '0;
  sys_ctrl_rsp dut (
    .CLK(CLK), .RST_N(RST_N), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
    .RF_ADDR_O(RF_ADDR_O), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge CLK) begin
    #1;
    RF_RD_DATA_VLD = 1'b0;
    if (RF_WR_EN) begin
      if (exp_wr.size() == 0) chk("wr_unexp", 32'(RF_WR_EN), 32'd0);
      else begin
        e = exp_wr.pop_front();
        chk("rf_wr", 32'({RF_ADDR_O, RF_WR_DATA}), e);
      end
      mem[RF_ADDR_O] = RF_WR_DATA;
    end
    if (RF_RD_EN) begin
      if (exp_rd.size() == 0) chk("rd_unexp", 32'(RF_RD_EN), 32'd0);
      else begin
        e = exp_rd.pop_front();
        chk("rf_rd_addr", 32'(RF_ADDR_O), e);
      end
      RF_RD_DATA     = mem[RF_ADDR_O];
      RF_RD_DATA_VLD = 1'b1;
    end
    if (TX_D_VLD) begin
      if (FIFO_FULL) chk("tx_while_full", 32'(TX_D_VLD), 32'd0);
      if (exp_tx.size() == 0) chk("tx_unexp", 32'(TX_D_VLD), 32'd0);
      else begin
        e = exp_tx.pop_front();
        chk("tx_byte", 32'(TX_P_DATA), e);
      end
    end
    if (ALU_EN || CLK_GATE_EN) chk("clk_gate", 32'(CLK_GATE_EN), 32'(ALU_EN));
    if (ALU_OUT_VLD) ALU_OUT_VLD = 1'b0;
    else if (ALU_EN) begin
      alu_cnt++;
      if (alu_cnt == 3) begin
        chk("alu_fun", 32'(ALU_FUN), 32'(exp_fun));
        ALU_OUT     = alu_res;
        ALU_OUT_VLD = 1'b1;
        alu_cnt     = 0;
      end
    end
  end
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    chk("drain", 32'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 32'd0);
    repeat (3) @(posedge CLK);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk(tag, 32'({RF_WR_EN, RF_RD_EN, TX_D_VLD, ALU_EN, CLK_GATE_EN}), 32'd0);
    chk({tag, "_addr"}, 32'(RF_ADDR_O), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle_outputs("rst_strobes");
    chk("rst_wr_data", 32'(RF_WR_DATA), 32'd0);
    chk("rst_fun", 32'(ALU_FUN), 32'd0);
    chk("rst_tx_data", 32'(TX_P_DATA), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    exp_wr.push_back(32'h53C);
    send(8'hAA); send(8'h05); send(8'h3C);
    drain();
    exp_rd.push_back(32'd5);
    exp_tx.push_back(32'h3C);
    send(8'hBB); send(8'h05);
    drain();
    alu_res = 16'h0014; exp_fun = 4'd2;
    exp_wr.push_back(32'h00A); exp_wr.push_back(32'h102);
    exp_tx.push_back(32'h14); exp_tx.push_back(32'h00);
    send(8'hCC); send(8'h0A); send(8'h02); send(8'h02);
    drain();
    alu_res = 16'h0008; exp_fun = 4'd1;
    exp_tx.push_back(32'h08); exp_tx.push_back(32'h00);
    send(8'hDD); send(8'h01);
    drain();
    exp_wr.push_back(32'h711);
    send(8'hAA); send(8'hF7); send(8'h11);
    drain();
    exp_rd.push_back(32'd7);
    exp_tx.push_back(32'h11);
    send(8'hBB); send(8'h17);
    drain();
    alu_res = 16'h0014; exp_fun = 4'd2;
    exp_wr.push_back(32'h00A); exp_wr.push_back(32'h102);
    exp_tx.push_back(32'h14); exp_tx.push_back(32'h00);
    @(negedge CLK);
    FIFO_FULL = 1'b1;
    send(8'hCC); send(8'h0A); send(8'h02); send(8'h02);
    repeat (10) @(negedge CLK);
    chk("full_held", 32'(exp_tx.size()), 32'd2);
    FIFO_FULL = 1'b0;
    drain();
    send(8'h55); send(8'hAA); send(8'h05);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk_idle_outputs("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    exp_rd.push_back(32'd5);
    exp_tx.push_back(32'h3C);
    send(8'hBB); send(8'h05);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
